ysyx_25020037_gpr_sb: RTL and testbench
=======================================

YSYX_25020037_GPR_SB -- requirements
Module: ysyx_25020037_gpr_sb

Interface
REQ-001 SHALL have parameter NREG, default 16, number of tracked GPRs (x0..x15).
REQ-002 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter.
REQ-003 SHALL have parameter MAX_INFL, default 4, maximum total in-flight instructions.
REQ-004 SHALL have ports: clk  in  1  single clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 iss_valid  in  1  IDU offers an instruction for issue.
REQ-007 iss_ready  out  1  scoreboard permits issue; issue fires on iss_valid & iss_ready.
REQ-008 iss_rs1 / iss_rs2  in  4 each  source register indices.
REQ-009 iss_rs1_en / iss_rs2_en  in  1 each  source actually read.
REQ-010 iss_rd  in  4  destination index; iss_rd_en  in  1  destination written.
REQ-011 iss_csr  in  1  instruction reads or writes a CSR (csrr*, ecall, mret).
REQ-012 wb_valid  in  1  WBU retires an instruction (same qualifier the register file uses as its write strobe).
REQ-013 wb_rd  in  4  retired destination; wb_rd_en  in  1  retired instruction wrote GPR.
REQ-014 wb_csr  in  1  retired instruction was CSR-class.
REQ-015 flush  in  1  discard all in-flight tracking.
REQ-016 infl_cnt  out  3  current in-flight count.
REQ-017 sb_err  out  1  sticky underflow error flag.

Function
REQ-018 SHALL hold pend[i] (CNT_W bits) per register, csr_pend (CNT_W bits) and infl (3 bits).
REQ-019 Register 0 SHALL never be tracked: pend[0] stays 0; rd=0 issue/retire ignored for pend.
REQ-020 RAW stall SHALL assert when (rs1_en & pend[rs1]!=0) or (rs2_en & pend[rs2]!=0).
REQ-021 WAW saturation stall SHALL assert when rd_en & rd!=0 & pend[rd]==all-ones.
REQ-022 CSR stall SHALL assert when iss_csr & csr_pend!=0 (CSRs serialized).
REQ-023 Capacity stall SHALL assert when infl==MAX_INFL.
REQ-024 iss_ready SHALL be the combinational NOR of all stalls; iss_ready independent of iss_valid.
REQ-025 On issue fire: infl+1, pend[rd]+1 if rd_en & rd!=0, csr_pend+1 if iss_csr; registered next edge.
REQ-026 On wb_valid: infl-1, pend[wb_rd]-1 if wb_rd_en & wb_rd!=0, csr_pend-1 if wb_csr.
REQ-027 Issue and retire on same register same cycle SHALL leave its counter unchanged; same for infl.
REQ-028 Decrement of a zero counter SHALL saturate at 0 and set sb_err, cleared only by rst.
REQ-029 flush SHALL zero all pend, csr_pend, infl next edge, overriding same-cycle issue and wb.
REQ-030 Latency: counter update visible one cycle after fire/retire edge.

Reset
REQ-031 On rst asserted (asynchronous): all pend, csr_pend, infl = 0, sb_err = 0; iss_ready = 1 while iss inputs hazard-free.
REQ-032 Reset mid-operation SHALL discard all tracking; no retire after reset is credited.

Configuration
REQ-033 Macro YSYX_25020037_SB_BYPASS_EN defined: stall checks (REQ-020..023) SHALL use counters already decremented by same-cycle wb_valid, allowing dependent issue in the retire cycle.
REQ-034 Macro undefined: stall checks SHALL use registered counters only (one extra bubble).

Structure
REQ-035 NREG, CNT_W, MAX_INFL defaults and the issue/wb bus widths SHALL live in the shared config header.
REQ-036 One sub-module ysyx_25020037_sb_cnt (saturating up/down counter with clear, underflow flag) SHALL be instanced per register and for CSR.

Verification
REQ-037 Issue rd=5, then rs1=5 next cycle, no wb -> iss_ready=0 until wb_rd=5; with BYPASS_EN ready=1 in wb cycle, without ready=1 cycle after.
REQ-038 Issue rd=0 then rs1=0 -> iss_ready stays 1, pend[0]=0.
REQ-039 Four issues without wb -> infl_cnt=4, fifth iss_ready=0; one wb -> infl_cnt=3, ready=1.
REQ-040 Issue rd=7 and wb_rd=7 same cycle with pend[7]=1 -> pend[7] remains 1.
REQ-041 wb_valid with wb_rd=3 while pend[3]=0 -> pend[3]=0, sb_err=1 and sticky until rst.
REQ-042 infl_cnt=3, flush with simultaneous issue -> next cycle infl_cnt=0, all pend 0; rst mid-stall -> iss_ready=1 immediately.

Source files
------------

// File: rtl/ysyx_25020037_gpr_sb_pkg.sv
// Shared configuration for the GPR scoreboard: default sizes and the issue/retire bus structs.
package ysyx_25020037_gpr_sb_pkg;
  localparam int SB_NREG     = 16;
  localparam int SB_CNT_W    = 2;
  localparam int SB_MAX_INFL = 4;
  localparam int REG_IDX_W   = 4;
  localparam int INFL_W      = 3;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rs1;
    logic                 rs1_en;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs2_en;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_en;
    logic                 csr;
  } sb_iss_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_en;
    logic                 csr;
  } sb_wb_t;
endpackage

// File: rtl/ysyx_25020037_gpr_sb_if.sv
// Issue (IDU side) and retire (WBU side) buses seen by the GPR scoreboard.
interface ysyx_25020037_gpr_sb_if;
  import ysyx_25020037_gpr_sb_pkg::*;

  logic    iss_valid;
  logic    iss_ready;
  sb_iss_t iss;
  logic    wb_valid;
  sb_wb_t  wb;

  modport master (output iss_valid, iss, wb_valid, wb, input iss_ready);
  modport slave  (input iss_valid, iss, wb_valid, wb, output iss_ready);
endinterface

// File: rtl/ysyx_25020037_sb_cnt.sv
// Saturating up/down pending counter with synchronous clear and an underflow pulse.
module ysyx_25020037_sb_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         udf
);
  logic [W-1:0] cnt_nxt;
  logic         zero, full;

  assign zero = (cnt == '0);
  assign full = (cnt == '1);
  // A retire matched by a same-cycle issue nets to zero and is never an underflow.
  assign udf  = dec & ~inc & zero & ~clr;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)                    cnt_nxt = '0;
    else if (inc & ~dec & ~full) cnt_nxt = cnt + 1'b1;
    else if (dec & ~inc & ~zero) cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end
endmodule

// File: rtl/ysyx_25020037_gpr_sb.sv
// GPR/CSR hazard scoreboard gating IDU issue. Define YSYX_25020037_SB_BYPASS_EN to let
// stall checks see counters already decremented by a same-cycle retire.
module ysyx_25020037_gpr_sb
  import ysyx_25020037_gpr_sb_pkg::*;
#(
  parameter int NREG     = SB_NREG,
  parameter int CNT_W    = SB_CNT_W,
  parameter int MAX_INFL = SB_MAX_INFL
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_25020037_gpr_sb_if.slave sb,
  input  logic                  flush,
  output logic [INFL_W-1:0]     infl_cnt,
  output logic                  sb_err
);
  logic [NREG-1:0][CNT_W-1:0] pend, pend_chk;
  logic [NREG-1:0]            udf;
  logic [CNT_W-1:0]           csr_pend, csr_chk;
  logic [INFL_W-1:0]          infl_chk;
  logic                       csr_udf, infl_udf, fire;
  logic                       raw_stall, waw_stall, csr_stall, cap_stall;

  assign fire = sb.iss_valid & sb.iss_ready;

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == 0) begin : g_x0
      assign pend[g]     = '0;
      assign pend_chk[g] = '0;
      assign udf[g]      = 1'b0;
    end else begin : g_trk
      logic inc, dec;
      assign inc = fire & sb.iss.rd_en & (sb.iss.rd == REG_IDX_W'(g));
      assign dec = sb.wb_valid & sb.wb.rd_en & (sb.wb.rd == REG_IDX_W'(g));
      ysyx_25020037_sb_cnt #(.W(CNT_W)) u_cnt (
        .clk(clk), .rst(rst), .clr(flush), .inc(inc), .dec(dec),
        .cnt(pend[g]), .udf(udf[g])
      );
`ifdef YSYX_25020037_SB_BYPASS_EN
      assign pend_chk[g] = (dec && pend[g] != '0) ? pend[g] - 1'b1 : pend[g];
`else
      assign pend_chk[g] = pend[g];
`endif
    end
  end

  ysyx_25020037_sb_cnt #(.W(CNT_W)) u_csr (
    .clk(clk), .rst(rst), .clr(flush),
    .inc(fire & sb.iss.csr), .dec(sb.wb_valid & sb.wb.csr),
    .cnt(csr_pend), .udf(csr_udf)
  );

  ysyx_25020037_sb_cnt #(.W(INFL_W)) u_infl (
    .clk(clk), .rst(rst), .clr(flush),
    .inc(fire), .dec(sb.wb_valid),
    .cnt(infl_cnt), .udf(infl_udf)
  );

`ifdef YSYX_25020037_SB_BYPASS_EN
  assign csr_chk  = (sb.wb_valid && sb.wb.csr && csr_pend != '0) ? csr_pend - 1'b1 : csr_pend;
  assign infl_chk = (sb.wb_valid && infl_cnt != '0) ? infl_cnt - 1'b1 : infl_cnt;
`else
  assign csr_chk  = csr_pend;
  assign infl_chk = infl_cnt;
`endif

  // Ready is a pure function of the offered fields, never of iss_valid.
  always_comb begin
    raw_stall = (sb.iss.rs1_en && pend_chk[sb.iss.rs1] != '0) ||
                (sb.iss.rs2_en && pend_chk[sb.iss.rs2] != '0);
    waw_stall = sb.iss.rd_en && (sb.iss.rd != '0) && (pend_chk[sb.iss.rd] == '1);
    csr_stall = sb.iss.csr && (csr_chk != '0);
    cap_stall = (infl_chk == INFL_W'(MAX_INFL));
    sb.iss_ready = ~(raw_stall | waw_stall | csr_stall | cap_stall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 sb_err <= 1'b0;
    else if ((|udf) || csr_udf || infl_udf) sb_err <= 1'b1;
  end
endmodule

// File: tb/tb_ysyx_25020037_gpr_sb.sv
// Directed-vector bench for the GPR scoreboard; expectations hand-derived per cycle.
module tb_ysyx_25020037_gpr_sb;
`ifdef YSYX_25020037_SB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] infl_cnt;
  logic       sb_err;
  int         n_chk = 0;
  int         n_pass = 0;

  ysyx_25020037_gpr_sb_if sb_if();

  ysyx_25020037_gpr_sb dut (
    .clk(clk), .rst(rst), .sb(sb_if), .flush(flush),
    .infl_cnt(infl_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic idle();
    sb_if.iss_valid = 1'b0;
    sb_if.iss       = '0;
    sb_if.wb_valid  = 1'b0;
    sb_if.wb        = '0;
    flush           = 1'b0;
  endtask

  // Inputs change 1ns after the active edge; checks follow after a further settle.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic iss(input logic [3:0] rd);
    sb_if.iss_valid = 1'b1;
    sb_if.iss.rd    = rd;
    sb_if.iss.rd_en = 1'b1;
  endtask

  task automatic src(input logic v, input logic [3:0] rs1, input logic [3:0] rs2);
    sb_if.iss_valid  = v;
    sb_if.iss.rs1    = rs1;
    sb_if.iss.rs1_en = 1'b1;
    sb_if.iss.rs2    = rs2;
    sb_if.iss.rs2_en = 1'b1;
  endtask

  task automatic wb(input logic [3:0] rd);
    sb_if.wb_valid = 1'b1;
    sb_if.wb.rd    = rd;
    sb_if.wb.rd_en = 1'b1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_ready", sb_if.iss_ready, 1);
    chk("rst_infl", infl_cnt, 0);
    chk("rst_err", sb_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // RAW on x5, released by its retire
    cyc(); iss(5); #1; chk("raw_issue_rdy", sb_if.iss_ready, 1);
    cyc(); src(1, 5, 0); #1; chk("raw_stall", sb_if.iss_ready, 0); chk("raw_infl", infl_cnt, 1);
    cyc(); src(1, 5, 0); #1; chk("raw_hold", sb_if.iss_ready, 0);
    cyc(); src(0, 5, 0); wb(5); #1; chk("raw_wb_cycle", sb_if.iss_ready, BYP);
    cyc(); src(1, 5, 0); #1; chk("raw_after_wb", sb_if.iss_ready, 1); chk("raw_infl0", infl_cnt, 0);

    // x0 is never tracked
    cyc(); do_rst(); iss(0); #1; chk("x0_issue", sb_if.iss_ready, 1);
    cyc(); src(1, 0, 0); #1; chk("x0_src", sb_if.iss_ready, 1); chk("x0_infl1", infl_cnt, 1);
    cyc(); #1; chk("x0_infl2", infl_cnt, 2);

    // capacity limit
    cyc(); do_rst(); iss(1);
    cyc(); iss(2);
    cyc(); iss(3);
    cyc(); iss(4); #1; chk("cap_rdy_4th", sb_if.iss_ready, 1);
    cyc(); sb_if.iss_valid = 1'b1; #1; chk("cap_infl4", infl_cnt, 4); chk("cap_full", sb_if.iss_ready, 0);
    cyc(); wb(1); #1; chk("cap_wb_cycle", sb_if.iss_ready, BYP);
    cyc(); sb_if.iss_valid = 1'b1; #1; chk("cap_infl3", infl_cnt, 3); chk("cap_free", sb_if.iss_ready, 1);

    // WAW saturation at pend==3 while capacity remains
    cyc(); do_rst(); iss(6);
    cyc(); iss(6);
    cyc(); iss(6);
    cyc(); iss(6); #1; chk("waw_sat", sb_if.iss_ready, 0); chk("waw_infl3", infl_cnt, 3);
    sb_if.iss.rd = 4'd8; #1; chk("waw_other_rd", sb_if.iss_ready, 1);

    // CSR serialisation
    cyc(); do_rst(); sb_if.iss_valid = 1'b1; sb_if.iss.csr = 1'b1;
    cyc(); sb_if.iss_valid = 1'b1; sb_if.iss.csr = 1'b1; #1; chk("csr_stall", sb_if.iss_ready, 0);
    sb_if.iss.csr = 1'b0; #1; chk("csr_noncsr", sb_if.iss_ready, 1);

    // same-cycle issue and retire on x7
    cyc(); do_rst(); iss(7);
    cyc(); iss(7); wb(7); #1; chk("same_rdy", sb_if.iss_ready, 1);
    cyc(); #1; chk("same_infl1", infl_cnt, 1);
    src(0, 7, 0); #1; chk("same_pend_busy", sb_if.iss_ready, 0);
    cyc(); wb(7);
    cyc(); src(0, 7, 0); #1; chk("same_pend_clear", sb_if.iss_ready, 1);
    chk("same_infl0", infl_cnt, 0); chk("same_err", sb_err, 0);

    // underflow is sticky until reset
    cyc(); wb(3);
    cyc(); src(0, 3, 0); #1; chk("udf_err", sb_err, 1); chk("udf_infl", infl_cnt, 0);
    chk("udf_pend", sb_if.iss_ready, 1);
    cyc(); flush = 1'b1;
    cyc(); #1; chk("udf_sticky", sb_err, 1);
    cyc(); do_rst(); #1; chk("udf_rst_clear", sb_err, 0);

    // flush overrides a same-cycle issue
    cyc(); iss(1);
    cyc(); iss(2);
    cyc(); iss(3);
    cyc(); #1; chk("fl_infl3", infl_cnt, 3);
    iss(4); flush = 1'b1;
    cyc(); src(0, 1, 4); #1; chk("fl_infl0", infl_cnt, 0); chk("fl_pend_1_4", sb_if.iss_ready, 1);
    src(0, 2, 3); #1; chk("fl_pend_2_3", sb_if.iss_ready, 1);

    // asynchronous reset mid-stall, then a stale retire
    cyc(); iss(9);
    cyc(); src(1, 9, 0); #1; chk("rst_mid_stall", sb_if.iss_ready, 0);
    rst = 1'b1; #1; chk("rst_mid_rdy", sb_if.iss_ready, 1); chk("rst_mid_infl", infl_cnt, 0);
    sb_if.iss_valid = 1'b0; #1; rst = 1'b0;
    cyc(); wb(9);
    cyc(); src(0, 9, 0); #1; chk("stale_wb_infl", infl_cnt, 0); chk("stale_wb_err", sb_err, 1);
    chk("stale_wb_rdy", sb_if.iss_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
